// File: rtl/chip_select_ctrl.sv
// chip_select_ctrl
//   Decodes a bus address strobe into one of eight active-low chip selects.
//   A programmable number of wait states is inserted before dtack_n is
//   asserted. A cycle to a disabled region answers with berr_n instead.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   as_n       in   address strobe, active-low
//   a[2:0]     in   region select, sampled with as_n
//   en         in   global decode enable
//   region_en  in   per-region enable mask
//   ws_cfg     in   per-region wait states, region i at [i*WS_W +: WS_W]
//   cs_n[7:0]  out  one-hot-low chip selects
//   dtack_n    out  data transfer acknowledge, active-low
//   berr_n     out  bus error, active-low
//   busy       out  high whenever a cycle is in progress
module chip_select_ctrl #(
  parameter int WS_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              as_n,
  input  logic [2:0]        a,
  input  logic              en,
  input  logic [7:0]        region_en,
  input  logic [8*WS_W-1:0] ws_cfg,
  output logic [7:0]        cs_n,
  output logic              dtack_n,
  output logic              berr_n,
  output logic              busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;
  localparam logic [1:0] ST_BERR = 2'd3;

  logic [1:0]      state_q,   state_d;
  logic [2:0]      region_q,  region_d;
  logic [WS_W-1:0] cnt_q,     cnt_d;
  logic            armed_q,   armed_d;
  logic [7:0]      cs_n_q,    cs_n_d;
  logic            dtack_n_q, dtack_n_d;
  logic            berr_n_q,  berr_n_d;
  logic            busy_q,    busy_d;

  always_comb begin
    state_d  = state_q;
    region_d = region_q;
    cnt_d    = cnt_q;
    // armed tracks the previous as_n sample: a new cycle needs a fresh falling strobe
    armed_d  = as_n;

    case (state_q)
      ST_IDLE: begin
        if (en && !as_n && armed_q) begin
          if (region_en[a]) begin
            state_d  = ST_WAIT;
            region_d = a;
            cnt_d    = ws_cfg[int'(a)*WS_W +: WS_W];
          end else begin
            state_d  = ST_BERR;
          end
        end
      end
      ST_WAIT: begin
        // strobe release aborts the cycle before any acknowledge
        if (as_n) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_ACK: begin
        if (as_n) state_d = ST_IDLE;
      end
      ST_BERR: begin
        if (as_n) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // outputs are registered copies of the decoded next state
    cs_n_d    = '1;
    if (state_d == ST_WAIT || state_d == ST_ACK) cs_n_d = ~(8'd1 << region_d);
    dtack_n_d = (state_d != ST_ACK);
    berr_n_d  = (state_d != ST_BERR);
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      region_q  <= '0;
      cnt_q     <= '0;
      armed_q   <= 1'b1;
      cs_n_q    <= '1;
      dtack_n_q <= 1'b1;
      berr_n_q  <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      region_q  <= region_d;
      cnt_q     <= cnt_d;
      armed_q   <= armed_d;
      cs_n_q    <= cs_n_d;
      dtack_n_q <= dtack_n_d;
      berr_n_q  <= berr_n_d;
      busy_q    <= busy_d;
    end
  end

  assign cs_n    = cs_n_q;
  assign dtack_n = dtack_n_q;
  assign berr_n  = berr_n_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_chip_select_ctrl.sv
// Testbench for chip_select_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// transaction-level model.
module tb_chip_select_ctrl;

  localparam int WS_W = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              as_n;
  logic [2:0]        a;
  logic              en;
  logic [7:0]        region_en;
  logic [8*WS_W-1:0] ws_cfg;
  logic [7:0]        cs_n;
  logic              dtack_n;
  logic              berr_n;
  logic              busy;

  int n_checks = 0;
  int n_pass   = 0;

  chip_select_ctrl #(.WS_W(WS_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .as_n      (as_n),
    .a         (a),
    .en        (en),
    .region_en (region_en),
    .ws_cfg    (ws_cfg),
    .cs_n      (cs_n),
    .dtack_n   (dtack_n),
    .berr_n    (berr_n),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- transaction-level reference model ----------------
  bit       m_active;     // a bus cycle is being served
  bit       m_err;        // cycle targets a disabled region
  bit       m_acked;      // acknowledge has been reached
  int       m_region;
  int       m_remaining;  // edges left until acknowledge
  bit       m_armed = 1;  // previous strobe sample was high

  always @(posedge clk) begin
    if (rst) begin
      m_active = 0;
      m_armed  = 1;
    end else begin
      if (!m_active) begin
        if (en && !as_n && m_armed) begin
          m_active    = 1;
          m_region    = int'(a);
          m_err       = !region_en[a];
          m_acked     = 0;
          m_remaining = ((int'(ws_cfg) >> (m_region * WS_W)) & ((1 << WS_W) - 1)) + 1;
        end
      end else if (as_n) begin
        m_active = 0;
      end else if (!m_err && !m_acked) begin
        m_remaining--;
        if (m_remaining == 0) m_acked = 1;
      end
      m_armed = as_n;
    end
    #1;
    begin
      logic [7:0] exp_cs;
      exp_cs = 8'hFF;
      if (m_active && !m_err) exp_cs[m_region] = 1'b0;
      chk("cs_n",    cs_n,    exp_cs);
      chk("dtack_n", dtack_n, !(m_active && !m_err && m_acked));
      chk("berr_n",  berr_n,  !(m_active && m_err));
      chk("busy",    busy,    m_active);
      chk("ack_berr_exclusive", dtack_n | berr_n, 1);
    end
  end

  task automatic edge_chk();
    @(posedge clk); #2;
  endtask

  initial begin
    rst = 1'b1; as_n = 1'b1; a = '0; en = 1'b1; region_en = 8'hFF; ws_cfg = '0;
    #1;
    chk("rst_cs_n", cs_n, 8'hFF);
    chk("rst_dtack", dtack_n, 1);
    chk("rst_berr", berr_n, 1);
    chk("rst_busy", busy, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // region 2, zero wait states
    ws_cfg = '0; a = 3'b010; as_n = 1'b0;
    edge_chk();
    chk("r2_cs_n_N", cs_n, 8'hFB);
    chk("r2_dtack_N", dtack_n, 1);
    edge_chk();
    chk("r2_dtack_N1", dtack_n, 0);
    chk("r2_cs_n_N1", cs_n, 8'hFB);
    @(negedge clk); as_n = 1'b1; a = 3'b111;
    edge_chk();
    chk("r2_release_cs", cs_n, 8'hFF);
    chk("r2_release_dtack", dtack_n, 1);
    chk("r2_release_busy", busy, 0);

    // region 5, three wait states
    @(negedge clk);
    ws_cfg = '0; ws_cfg[15 +: 3] = 3'd3; a = 3'b101; as_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      edge_chk();
      chk("r5_cs_n", cs_n, 8'hDF);
      chk("r5_dtack_early", dtack_n, 1);
      if (i == 0) begin a = 3'b000; ws_cfg = '0; end
    end
    edge_chk();
    chk("r5_dtack_N4", dtack_n, 0);
    @(negedge clk); as_n = 1'b1;
    edge_chk();
    chk("r5_release_busy", busy, 0);

    // disabled region 6 -> bus error
    @(negedge clk);
    region_en = 8'hBF; a = 3'b110; as_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      edge_chk();
      chk("berr_berr_n", berr_n, 0);
      chk("berr_cs_n", cs_n, 8'hFF);
      chk("berr_dtack", dtack_n, 1);
      region_en = 8'hFF;
    end
    @(negedge clk); as_n = 1'b1;
    edge_chk();
    chk("berr_release", berr_n, 1);

    // region 3, seven wait states, aborted at N+3
    @(negedge clk);
    ws_cfg = '0; ws_cfg[9 +: 3] = 3'd7; a = 3'b011; as_n = 1'b0;
    edge_chk(); edge_chk();
    edge_chk();
    @(negedge clk); as_n = 1'b1;
    edge_chk();
    chk("abort_cs_n", cs_n, 8'hFF);
    chk("abort_busy", busy, 0);
    for (int i = 0; i < 8; i++) begin
      edge_chk();
      chk("abort_no_dtack", dtack_n, 1);
    end

    // en=0 with strobe held low, then enable without re-arming
    @(negedge clk);
    en = 1'b0; a = 3'b000; as_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      edge_chk();
      chk("dis_busy", busy, 0);
      chk("dis_cs_n", cs_n, 8'hFF);
    end
    @(negedge clk); en = 1'b1;
    edge_chk(); edge_chk();
    chk("rearm_busy", busy, 0);
    @(negedge clk); as_n = 1'b1;

    // reset during wait states of region 1
    @(negedge clk);
    ws_cfg = '0; ws_cfg[3 +: 3] = 3'd5; a = 3'b001; as_n = 1'b0;
    edge_chk();
    chk("rstw_cs_n", cs_n, 8'hFD);
    edge_chk();
    #1 rst = 1'b1;
    #1;
    chk("rstw_async_cs", cs_n, 8'hFF);
    chk("rstw_async_busy", busy, 0);
    chk("rstw_async_dtack", dtack_n, 1);
    @(negedge clk); as_n = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      edge_chk();
      chk("rstw_no_dtack", dtack_n, 1);
    end

    // randomized traffic, checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        #1;
        chk("rand_async_rst", {cs_n, dtack_n, berr_n, busy}, {8'hFF, 1'b1, 1'b1, 1'b0});
      end
      if (as_n) as_n = ($urandom_range(0, 2) != 0);
      else      as_n = ($urandom_range(0, 5) == 0);
      en        = ($urandom_range(0, 7) != 0);
      a         = 3'($urandom);
      region_en = 8'($urandom) | 8'($urandom);
      ws_cfg    = (8*WS_W)'($urandom);
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
